// File: rtl/dual_lane_buffer_lane_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lane_fifo
//  Description : Synchronous first-word-fall-through FIFO for one output lane.
//                The head entry is always visible on o_data_out; occupancy
//                is tracked by an explicit count that drives full/empty.
//  Revision    : 1.0  initial release
// ============================================================================
module lane_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data_in,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Guard locally as well so the FIFO is safe even if a caller misbehaves.
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop  && !w_empty;

    // Storage array: data only, no reset needed since reads are masked by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_data_out = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/dual_lane_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dual_lane_buffer
//  Description : Captures the lane chosen by the upstream 1-to-2 selector and
//                queues it in one of two independent FWFT FIFOs, each with its
//                own valid/ready consumer handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_lane_buffer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VALID_IN,
    input  logic             SELECT,
    input  logic [WIDTH-1:0] DATA_IN_0,
    input  logic [WIDTH-1:0] DATA_IN_1,
    output logic             READY_IN,
    output logic [WIDTH-1:0] DATA_OUT_0,
    output logic             VALID_OUT_0,
    input  logic             READY_OUT_0,
    output logic [WIDTH-1:0] DATA_OUT_1,
    output logic             VALID_OUT_1,
    input  logic             READY_OUT_1,
    output logic [CNT_W-1:0] COUNT_0,
    output logic [CNT_W-1:0] COUNT_1
);

    logic             w_full_0;
    logic             w_full_1;
    logic             w_empty_0;
    logic             w_empty_1;
    logic             w_push_0;
    logic             w_push_1;
    logic             w_pop_0;
    logic             w_pop_1;
    logic [WIDTH-1:0] w_head_0;
    logic [WIDTH-1:0] w_head_1;

    // Ready reflects only the lane being addressed; a full idle lane never
    // back-pressures traffic to the other one.
    assign READY_IN = SELECT ? !w_full_1 : !w_full_0;

    // Exactly one lane can be pushed per cycle.
    assign w_push_0 = VALID_IN && READY_IN && (SELECT == 1'b0);
    assign w_push_1 = VALID_IN && READY_IN && (SELECT == 1'b1);

    assign VALID_OUT_0 = !w_empty_0;
    assign VALID_OUT_1 = !w_empty_1;

    assign w_pop_0 = VALID_OUT_0 && READY_OUT_0;
    assign w_pop_1 = VALID_OUT_1 && READY_OUT_1;

    // Stale array contents never leak to the consumers.
    assign DATA_OUT_0 = VALID_OUT_0 ? w_head_0 : '0;
    assign DATA_OUT_1 = VALID_OUT_1 ? w_head_1 : '0;

    lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane_0 (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_push     (w_push_0),
        .i_data_in  (DATA_IN_0),
        .o_full     (w_full_0),
        .i_pop      (w_pop_0),
        .o_data_out (w_head_0),
        .o_empty    (w_empty_0),
        .o_count    (COUNT_0)
    );

    lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane_1 (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_push     (w_push_1),
        .i_data_in  (DATA_IN_1),
        .o_full     (w_full_1),
        .i_pop      (w_pop_1),
        .o_data_out (w_head_1),
        .o_empty    (w_empty_1),
        .o_count    (COUNT_1)
    );

`ifndef SYNTHESIS
    // An unknown lane select with a live word would steer data unpredictably.
    always @(posedge CLK) begin
        if (RST_N && VALID_IN) begin
            assert (!$isunknown(SELECT))
                else $error("dual_lane_buffer: SELECT unknown while VALID_IN=1");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_lane_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_lane_buffer
//  Description : Directed, table-driven bench for dual_lane_buffer plus
//                hand-written sequences for streaming wrap and mid-run reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_lane_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             VALID_IN;
    logic             SELECT;
    logic [WIDTH-1:0] DATA_IN_0;
    logic [WIDTH-1:0] DATA_IN_1;
    logic             READY_IN;
    logic [WIDTH-1:0] DATA_OUT_0;
    logic             VALID_OUT_0;
    logic             READY_OUT_0;
    logic [WIDTH-1:0] DATA_OUT_1;
    logic             VALID_OUT_1;
    logic             READY_OUT_1;
    logic [CNT_W-1:0] COUNT_0;
    logic [CNT_W-1:0] COUNT_1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dual_lane_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .VALID_IN    (VALID_IN),
        .SELECT      (SELECT),
        .DATA_IN_0   (DATA_IN_0),
        .DATA_IN_1   (DATA_IN_1),
        .READY_IN    (READY_IN),
        .DATA_OUT_0  (DATA_OUT_0),
        .VALID_OUT_0 (VALID_OUT_0),
        .READY_OUT_0 (READY_OUT_0),
        .DATA_OUT_1  (DATA_OUT_1),
        .VALID_OUT_1 (VALID_OUT_1),
        .READY_OUT_1 (READY_OUT_1),
        .COUNT_0     (COUNT_0),
        .COUNT_1     (COUNT_1)
    );

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic        sel;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        chk_rdy;
        logic        exp_rdy;
        int          c0;
        int          c1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rst_n, input logic valid, input logic sel,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic r0, input logic r1,
                                input logic chk_rdy, input logic exp_rdy,
                                input int c0, input int c1,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.sel = sel;
        v.d0 = d0; v.d1 = d1; v.r0 = r0; v.r1 = r1;
        v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy;
        v.c0 = c0; v.c1 = c1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_n, input logic valid, input logic sel,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic r0, input logic r1);
        RST_N       = rst_n;
        VALID_IN    = valid;
        SELECT      = sel;
        DATA_IN_0   = d0;
        DATA_IN_1   = d1;
        READY_OUT_0 = r0;
        READY_OUT_1 = r1;
    endtask

    // Post-edge check of both lanes; valid is implied by a nonzero count and
    // data must read zero whenever the lane is empty.
    task automatic check_state(input string tag, input int c0, input int c1,
                               input logic [31:0] e0, input logic [31:0] e1);
        check({tag, ".COUNT_0"},     32'(COUNT_0),     32'(c0));
        check({tag, ".COUNT_1"},     32'(COUNT_1),     32'(c1));
        check({tag, ".VALID_OUT_0"}, 32'(VALID_OUT_0), 32'(c0 != 0));
        check({tag, ".VALID_OUT_1"}, 32'(VALID_OUT_1), 32'(c1 != 0));
        check({tag, ".DATA_OUT_0"},  DATA_OUT_0,       e0);
        check({tag, ".DATA_OUT_1"},  DATA_OUT_1,       e1);
    endtask

    initial begin
        // rst  vld sel d0         d1          r0 r1  chkR expR  c0 c1  e0         e1
        tbl[0]  = mk(0, 1, 0, 32'hAA, 32'hBB, 0, 0, 0, 1, 0, 0, 32'h00, 32'h00);
        tbl[1]  = mk(0, 1, 0, 32'hAA, 32'hBB, 0, 0, 1, 1, 0, 0, 32'h00, 32'h00);
        // Steering with both consumers stalled.
        tbl[2]  = mk(1, 1, 0, 32'h11, 32'hDEAD, 0, 0, 1, 1, 1, 0, 32'h11, 32'h00);
        tbl[3]  = mk(1, 1, 1, 32'hBEEF, 32'h22, 0, 0, 1, 1, 1, 1, 32'h11, 32'h22);
        tbl[4]  = mk(1, 1, 0, 32'h33, 32'hCAFE, 0, 0, 1, 1, 2, 1, 32'h11, 32'h22);
        // Release lane 0: 0x11 then 0x33.
        tbl[5]  = mk(1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1, 1, 1, 32'h33, 32'h22);
        tbl[6]  = mk(1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 1, 32'h00, 32'h22);
        tbl[7]  = mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 0, 1, 0, 0, 32'h00, 32'h00);
        // Fill lane 0.
        tbl[8]  = mk(1, 1, 0, 32'hA1, 32'h0, 0, 0, 1, 1, 1, 0, 32'hA1, 32'h00);
        tbl[9]  = mk(1, 1, 0, 32'hA2, 32'h0, 0, 0, 1, 1, 2, 0, 32'hA1, 32'h00);
        tbl[10] = mk(1, 1, 0, 32'hA3, 32'h0, 0, 0, 1, 1, 3, 0, 32'hA1, 32'h00);
        tbl[11] = mk(1, 1, 0, 32'hA4, 32'h0, 0, 0, 1, 1, 4, 0, 32'hA1, 32'h00);
        // Ready depends only on the selected lane.
        tbl[12] = mk(1, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0, 4, 0, 32'hA1, 32'h00);
        tbl[13] = mk(1, 0, 1, 32'h0, 32'h0, 0, 0, 1, 1, 4, 0, 32'hA1, 32'h00);
        // Fifth push refused.
        tbl[14] = mk(1, 1, 0, 32'hA5, 32'h0, 0, 0, 1, 0, 4, 0, 32'hA1, 32'h00);
        // Full with simultaneous pop: pop only, push lands the next cycle.
        tbl[15] = mk(1, 1, 0, 32'hA5, 32'h0, 1, 0, 1, 0, 3, 0, 32'hA2, 32'h00);
        tbl[16] = mk(1, 1, 0, 32'hA5, 32'h0, 0, 0, 1, 1, 4, 0, 32'hA2, 32'h00);
        // Push lane 1 while lane 0 pops: both complete.
        tbl[17] = mk(1, 1, 1, 32'hFF, 32'h77, 1, 0, 1, 1, 3, 1, 32'hA3, 32'h77);

        drive(1, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge CLK);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst_n, tbl[i].valid, tbl[i].sel, tbl[i].d0, tbl[i].d1,
                  tbl[i].r0, tbl[i].r1);
            #1;
            if (tbl[i].chk_rdy) begin
                check($sformatf("vec%0d.READY_IN", i), 32'(READY_IN), 32'(tbl[i].exp_rdy));
            end
            @(posedge CLK);
            #1;
            check_state($sformatf("vec%0d", i), tbl[i].c0, tbl[i].c1, tbl[i].e0, tbl[i].e1);
            @(negedge CLK);
        end

        // Mid-operation reset with lane 0 holding A3, A4, A5 and lane 1 holding 0x77.
        drive(0, 1, 0, 32'h99, 32'h0, 1, 1);
        @(posedge CLK); #1;
        check_state("midrst", 0, 0, 32'h0, 32'h0);
        @(negedge CLK);
        drive(1, 1, 0, 32'h55, 32'h0, 0, 0);
        #1;
        check("midrst.READY_IN", 32'(READY_IN), 32'h1);
        @(posedge CLK); #1;
        check_state("midrst.push55", 1, 0, 32'h55, 32'h0);
        @(negedge CLK);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 0);
        @(posedge CLK); #1;
        check_state("midrst.pop55", 0, 0, 32'h0, 32'h0);
        @(negedge CLK);

        // Streaming on lane 1 with the consumer always ready, across pointer wrap.
        for (int k = 1; k <= 10; k++) begin
            drive(1, 1, 1, 32'hDEAD, 32'(k), 0, 1);
            #1;
            check($sformatf("stream%0d.READY_IN", k), 32'(READY_IN), 32'h1);
            @(posedge CLK); #1;
            check_state($sformatf("stream%0d", k), 0, 1, 32'h0, 32'(k));
            @(negedge CLK);
        end
        drive(1, 0, 1, 32'h0, 32'h0, 0, 1);
        @(posedge CLK); #1;
        check_state("stream.drain", 0, 0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
